// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_pkg
//  Purpose  : Shared sizing constants for the csa64 carry-select adder.
//  Contents : CSA_WIDTH - operand/sum width
//             CSA_BLOCK - bits per carry-select block
//             CSA_NBLK  - number of carry-select blocks
//  Revision : 1.0 - initial release
// ============================================================================
package csa_pkg;
  localparam int CSA_WIDTH = 64;
  localparam int CSA_BLOCK = 8;
  localparam int CSA_NBLK  = CSA_WIDTH / CSA_BLOCK;
endpackage
`default_nettype wire

// File: rtl/csa64_if.sv
`default_nettype none
// ============================================================================
//  Module   : csa64_if
//  Purpose  : Operand/result bundle for the csa64 adder.
//  Signals  : a, b  - addends (unsigned or two's-complement)
//             ci    - carry in
//             s     - registered sum
//             co    - registered carry out of the top bit
//  Modports : master - drives operands, observes result
//             slave  - adder side
//  Revision : 1.0 - initial release
// ============================================================================
interface csa64_if #(
  parameter int WIDTH = csa_pkg::CSA_WIDTH
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (output a, output b, output ci, input s, input co);
  modport slave  (input a, input b, input ci, output s, output co);
endinterface
`default_nettype wire

// File: rtl/csa_block.sv
`default_nettype none
// ============================================================================
//  Module   : csa_block
//  Purpose  : One BLOCK-bit slice of the carry-select adder. In select mode
//             two ripple adders precompute the sum for carry-in 0 and 1 and
//             cin only drives the output mux. In ripple mode (lowest block)
//             a single ripple adder consumes cin directly.
//  Ports    : x, y - operand slices
//             cin  - carry into the slice
//             sum  - slice sum
//             cout - carry out of the slice
//  Revision : 1.0 - initial release
// ============================================================================
module csa_block
  import csa_pkg::*;
#(
  parameter int BLOCK       = CSA_BLOCK,
  parameter bit RIPPLE_ONLY = 1'b0
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  if (RIPPLE_ONLY) begin : g_ripple
    logic w_c;
    always_comb begin
      w_c = cin;
      sum = '0;
      for (int i = 0; i < BLOCK; i++) begin
        sum[i] = x[i] ^ y[i] ^ w_c;
        w_c    = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
      end
      cout = w_c;
    end
  end else begin : g_select
    logic [BLOCK-1:0] w_s0;
    logic [BLOCK-1:0] w_s1;
    logic             w_c0;
    logic             w_c1;

    // Both candidates are independent of cin, so the inter-block carry
    // sees only the final mux.
    always_comb begin
      w_c0 = 1'b0;
      w_c1 = 1'b1;
      w_s0 = '0;
      w_s1 = '0;
      for (int i = 0; i < BLOCK; i++) begin
        w_s0[i] = x[i] ^ y[i] ^ w_c0;
        w_c0    = (x[i] & y[i]) | (w_c0 & (x[i] ^ y[i]));
        w_s1[i] = x[i] ^ y[i] ^ w_c1;
        w_c1    = (x[i] & y[i]) | (w_c1 & (x[i] ^ y[i]));
      end
    end

    assign sum  = cin ? w_s1 : w_s0;
    assign cout = cin ? w_c1 : w_c0;
  end

endmodule
`default_nettype wire

// File: rtl/csa64.sv
`default_nettype none
// ============================================================================
//  Module   : csa64
//  Purpose  : 64-bit carry-select adder with a registered result stage.
//             {co, s} = a + b + ci, one cycle latency, one add per cycle.
//  Ports    : clk - rising-edge clock
//             rst - asynchronous active-high reset (clears s and co)
//             bus - csa64_if slave: a, b, ci in; s, co out
//  Revision : 1.0 - initial release
// ============================================================================
module csa64
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLOCK = CSA_BLOCK
) (
  input  logic         clk,
  input  logic         rst,
  csa64_if.slave       bus
);

  localparam int NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_co;

  // Each block keeps its own carry nets so the chain is a sequence of
  // distinct signals linked only through the block output muxes.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic w_cin;
    logic w_cout;

    if (k == 0) begin : g_first
      assign w_cin = bus.ci;
    end else begin : g_next
      assign w_cin = g_blk[k-1].w_cout;
    end

    csa_block #(
      .BLOCK       (BLOCK),
      .RIPPLE_ONLY (k == 0)
    ) u_blk (
      .x    (bus.a[k*BLOCK +: BLOCK]),
      .y    (bus.b[k*BLOCK +: BLOCK]),
      .cin  (w_cin),
      .sum  (w_sum[k*BLOCK +: BLOCK]),
      .cout (w_cout)
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s  <= '0;
      r_co <= 1'b0;
    end else begin
      r_s  <= w_sum;
      r_co <= g_blk[NBLK-1].w_cout;
    end
  end

  assign bus.s  = r_s;
  assign bus.co = r_co;

endmodule
`default_nettype wire

// File: tb/tb_csa64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa64
//  Purpose  : Self-checking bench for csa64. Expected results come from a
//             65-bit arithmetic reference sum computed in the bench.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa64;

  localparam int W = 64;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  csa64_if #(.WIDTH(W)) bus ();

  csa64 #(.WIDTH(W), .BLOCK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    bus.a  = a;
    bus.b  = b;
    bus.ci = ci;
  endtask

  // Drive on a falling edge, capture on the next rising edge, check on the
  // following falling edge.
  task automatic test_reset;
    logic [W:0] exp;
    @(negedge clk);
    drive(64'd5, 64'd6, 1'b0);
    checks++;
    if (bus.s !== '0 || bus.co !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: s=%h co=%b required s=0 co=0", bus.s, bus.co);
    end
    rst = 1'b0;
    exp = ref_sum(64'd5, 64'd6, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.co, bus.s} !== exp) begin
      failures++;
      $display("FAIL reset_release: s=%0d co=%b required s=%0d co=%b",
               bus.s, bus.co, exp[W-1:0], exp[W]);
    end
    // Assert mid-cycle: outputs must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.s !== '0 || bus.co !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: s=%h co=%b required s=0 co=0", bus.s, bus.co);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s !== 64'd11 || bus.co !== 1'b0) begin
      failures++;
      $display("FAIL reset_rerelease: s=%0d co=%b required s=11 co=0", bus.s, bus.co);
    end
  endtask

  task automatic test_signed;
    drive(64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.s !== 64'hFFFF_FFFF_FFFF_FFFC || bus.co !== 1'b0) begin
      failures++;
      $display("FAIL signed_add: s=%h co=%b required s=fffffffffffffffc co=0", bus.s, bus.co);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av [3] = '{64'd75, 64'd43, 64'd43};
    logic [W-1:0] bv [3] = '{64'd4,  64'd95, 64'd95};
    logic [W-1:0] ev [3] = '{64'd79, 64'd138, 64'd138};
    for (int i = 0; i < 3; i++) begin
      drive(av[i], bv[i], 1'b0);
      @(negedge clk);
      checks++;
      if (bus.s !== ev[i] || bus.co !== 1'b0) begin
        failures++;
        $display("FAIL back_to_back[%0d]: s=%0d co=%b required s=%0d co=0",
                 i, bus.s, bus.co, ev[i]);
      end
    end
  endtask

  task automatic test_full_carry;
    drive('1, '0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.s !== '0 || bus.co !== 1'b1) begin
      failures++;
      $display("FAIL full_carry: s=%h co=%b required s=0 co=1", bus.s, bus.co);
    end
    drive('1, '1, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.s !== {W{1'b1}} || bus.co !== 1'b1) begin
      failures++;
      $display("FAIL max_case: s=%h co=%b required s=ffffffffffffffff co=1", bus.s, bus.co);
    end
  endtask

  task automatic test_block_boundary;
    drive(64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.s !== 64'h0100_0100_0100_0100 || bus.co !== 1'b0) begin
      failures++;
      $display("FAIL block_boundary: s=%h co=%b required s=0100010001000100 co=0",
               bus.s, bus.co);
    end
    // A carry generated in the lowest block must ride every select mux.
    drive(64'hFFFF_FFFF_FFFF_FF00, 64'h0000_0000_0000_0080, 1'b0);
    @(negedge clk);
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1);
    checks++;
    if (bus.s !== 64'hFFFF_FFFF_FFFF_FF80 || bus.co !== 1'b0) begin
      failures++;
      $display("FAIL no_carry_chain: s=%h co=%b required s=ffffffffffffff80 co=0",
               bus.s, bus.co);
    end
    drive(64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.s !== '0 || bus.co !== 1'b1) begin
      failures++;
      $display("FAIL carry_chain: s=%h co=%b required s=0 co=1", bus.s, bus.co);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      2:       v = {$urandom, $urandom} | 64'hFFFF_FFFF_FFFF_FF00;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic test_random;
    logic [W:0]   exp;
    logic         have_exp = 1'b0;
    logic [W-1:0] a, b;
    logic         ci;
    for (int n = 0; n < 10000; n++) begin
      if (have_exp) begin
        checks++;
        if ({bus.co, bus.s} !== exp) begin
          failures++;
          $display("FAIL random[%0d]: s=%h co=%b required s=%h co=%b",
                   n, bus.s, bus.co, exp[W-1:0], exp[W]);
        end
      end
      have_exp = 1'b0;
      if (rst) begin
        checks++;
        if (bus.s !== '0 || bus.co !== 1'b0) begin
          failures++;
          $display("FAIL random_rst_hold[%0d]: s=%h co=%b required s=0 co=0", n, bus.s, bus.co);
        end
        rst = 1'b0;
      end
      a  = rand_word();
      b  = rand_word();
      ci = 1'($urandom_range(0, 1));
      drive(a, b, ci);
      if ($urandom_range(0, 149) == 0) begin
        // Pulse arrives mid-cycle; the add in flight is discarded.
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.s !== '0 || bus.co !== 1'b0) begin
          failures++;
          $display("FAIL random_rst_async[%0d]: s=%h co=%b required s=0 co=0", n, bus.s, bus.co);
        end
      end else begin
        exp      = ref_sum(a, b, ci);
        have_exp = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0, 1'b0);
    test_reset();
    test_signed();
    test_back_to_back();
    test_full_carry();
    test_block_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
